// File: rtl/period_meter_if.sv
// Interface bundling the measurement control inputs and the divider-facing
// outputs of period_meter. The slave side is the meter itself; the master
// side is whatever drives enable and the measured signal.
interface period_meter_if #(
  parameter int M = 30
);
  logic         en;
  logic         sig_in;
  logic [M-1:0] divisor;
  logic         div_vld;
  logic         quot_vld;
  logic         locked;
  logic         ovf;
  logic         too_short;

  modport master (
    output en,
    output sig_in,
    input  divisor,
    input  div_vld,
    input  quot_vld,
    input  locked,
    input  ovf,
    input  too_short
  );

  modport slave (
    input  en,
    input  sig_in,
    output divisor,
    output div_vld,
    output quot_vld,
    output locked,
    output ovf,
    output too_short
  );
endinterface

// File: rtl/period_meter.sv
// period_meter: measures the period of an asynchronous signal in clk cycles
// and presents it as the divisor word of a downstream pipelined divider.
// The divisor is clamped to the divider's legal range: short periods are
// rejected, and a missing edge saturates the divisor at 2**M-1. A copy of
// div_vld delayed by the divider latency marks when the quotient is valid.
module period_meter #(
  parameter int M            = 30,
  parameter int M_ACTIVE_MIN = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int DIV_LAT      = 28
) (
  input  logic           clk,
  input  logic           rstn,
  period_meter_if.slave  bus
);

  // Smallest divisor the divider accepts, and the saturated counter value.
  localparam logic [M-1:0] DIV_MIN = M'(1) << (M_ACTIVE_MIN - 1);
  localparam logic [M-1:0] CNT_MAX = {M{1'b1}};
  localparam logic [M-1:0] CNT_ONE = M'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   edge_det;

  state_t                 state_reg, state_next;
  logic [M-1:0]           cnt_reg, cnt_next;
  logic [M-1:0]           divisor_reg, divisor_next;
  logic                   div_vld_reg, div_vld_next;
  logic                   ovf_reg, ovf_next;
  logic                   too_short_reg, too_short_next;
  logic                   locked_reg, locked_next;
  logic [DIV_LAT-1:0]     dly_reg;

  // Bring sig_in into the clk domain and remember the last synchronized level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.sig_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Rising edge of the synchronized signal; both operands are flop outputs.
  assign edge_det = sync_reg[SYNC_STAGES-1] & ~prev_reg;

  // State, period counter and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      divisor_reg   <= DIV_MIN;
      div_vld_reg   <= 1'b0;
      ovf_reg       <= 1'b0;
      too_short_reg <= 1'b0;
      locked_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      divisor_reg   <= divisor_next;
      div_vld_reg   <= div_vld_next;
      ovf_reg       <= ovf_next;
      too_short_reg <= too_short_next;
      locked_reg    <= locked_next;
    end
  end

  // Next-state logic: en low overrides everything; in MEAS an edge closes the
  // current period (and wins over a simultaneous timeout), otherwise count.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    divisor_next   = divisor_reg;
    div_vld_next   = 1'b0;
    ovf_next       = 1'b0;
    too_short_next = 1'b0;
    locked_next    = locked_reg;

    if (!bus.en) begin
      state_next  = ST_IDLE;
      cnt_next    = '0;
      locked_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_ARM;
          cnt_next   = '0;
        end
        ST_ARM: begin
          // The first edge only opens a period; there is nothing to report yet.
          if (edge_det) begin
            state_next = ST_MEAS;
            cnt_next   = CNT_ONE;
          end
        end
        ST_MEAS: begin
          if (edge_det) begin
            cnt_next = CNT_ONE;
            if (cnt_reg >= DIV_MIN) begin
              divisor_next = cnt_reg;
              div_vld_next = 1'b1;
              locked_next  = 1'b1;
            end else begin
              too_short_next = 1'b1;
            end
          end else if (cnt_reg == CNT_MAX) begin
            // No edge for the full counter range: report a saturated divisor
            // so the divider still yields a (minimum) frequency.
            state_next   = ST_ARM;
            cnt_next     = '0;
            divisor_next = CNT_MAX;
            div_vld_next = 1'b1;
            ovf_next     = 1'b1;
            locked_next  = 1'b0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Divider-latency delay line for div_vld; it keeps draining even when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dly_reg <= '0;
    end else begin
      dly_reg <= {dly_reg[DIV_LAT-2:0], div_vld_reg};
    end
  end

  assign bus.divisor   = divisor_reg;
  assign bus.div_vld   = div_vld_reg;
  assign bus.quot_vld  = dly_reg[DIV_LAT-1];
  assign bus.locked    = locked_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.too_short = too_short_reg;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a default-width instance (M=30) for the
// normal measurement paths and an M=14 instance for timeout behaviour.
module tb_period_meter;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  period_meter_if #(.M(30)) ifa ();
  period_meter_if #(.M(14)) ifb ();

  period_meter #(.M(30), .M_ACTIVE_MIN(12), .SYNC_STAGES(2), .DIV_LAT(28)) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifa.slave)
  );

  period_meter #(.M(14), .M_ACTIVE_MIN(12), .SYNC_STAGES(2), .DIV_LAT(28)) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifb.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Event log for instance A, sampled on the falling edge.
  int n_div      = 0;
  int n_quot     = 0;
  int n_quot_raw = 0;
  int n_short    = 0;
  int n_ovf      = 0;
  int lat_bad    = 0;
  int wide       = 0;
  logic div_d    = 1'b0;
  logic short_d  = 1'b0;
  int div_cyc [0:63];
  int dv_vals [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rstn) begin
      n_quot  <= n_div;
      div_d   <= 1'b0;
      short_d <= 1'b0;
    end else begin
      if (ifa.div_vld) begin
        if (n_div < 64) begin
          div_cyc[n_div] <= cyc;
          dv_vals[n_div] <= int'(ifa.divisor);
        end
        n_div <= n_div + 1;
      end
      if (ifa.quot_vld) begin
        n_quot_raw <= n_quot_raw + 1;
        if (!(n_quot < n_div && n_quot < 64 && (cyc - div_cyc[n_quot]) == 28))
          lat_bad <= lat_bad + 1;
        n_quot <= n_quot + 1;
      end
      if (ifa.too_short) n_short <= n_short + 1;
      if (ifa.ovf) n_ovf <= n_ovf + 1;
      if ((ifa.div_vld && div_d) || (ifa.too_short && short_d)) wide <= wide + 1;
      div_d   <= ifa.div_vld;
      short_d <= ifa.too_short;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_sig(input int sel, input logic v);
    if (sel == 0) ifa.sig_in = v;
    else          ifb.sig_in = v;
  endtask

  // n rising edges spaced exactly per cycles; returns on the last cycle
  // before the next edge would be due.
  task automatic gen_edges(input int sel, input int per, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_sig(sel, 1'b1);
      repeat (per / 2) @(negedge clk);
      set_sig(sel, 1'b0);
      repeat (per - per / 2 - 1) @(negedge clk);
    end
  endtask

  // One rising edge, then wait (bounded) for div_vld; lat = cycles from edge.
  task automatic rise_wait(input int sel, output int lat);
    int c0;
    lat = -1;
    @(negedge clk);
    set_sig(sel, 1'b1);
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((sel == 0) ? ifa.div_vld : ifb.div_vld) begin
        lat = cyc - c0;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int c0;
    int dt;
    ifa.en = 1'b0; ifa.sig_in = 1'b0;
    ifb.en = 1'b0; ifb.sig_in = 1'b0;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_divisor",   ifa.divisor, 2048);
    chk("rst_div_vld",   ifa.div_vld, 0);
    chk("rst_quot_vld",  ifa.quot_vld, 0);
    chk("rst_locked",    ifa.locked, 0);
    chk("rst_ovf",       ifa.ovf, 0);
    chk("rst_too_short", ifa.too_short, 0);
    chk("rst_b_divisor", ifb.divisor, 2048);

    rstn = 1'b1;
    repeat (2) @(negedge clk);
    ifa.en = 1'b1;
    repeat (2) @(negedge clk);

    // Period 1000: every closing edge is rejected
    gen_edges(0, 1000, 4);
    chk("short_count",   n_short, 3);
    chk("short_no_div",  n_div, 0);
    chk("short_divisor", ifa.divisor, 2048);
    chk("short_locked",  ifa.locked, 0);

    ifa.en = 1'b0;
    repeat (2) @(negedge clk);
    ifa.en = 1'b1;
    repeat (2) @(negedge clk);

    // Period 4096
    gen_edges(0, 4096, 3);
    chk("p4096_count",   n_div, 2);
    chk("p4096_divisor", ifa.divisor, 4096);
    chk("p4096_locked",  ifa.locked, 1);
    chk("p4096_value",   dv_vals[1], 4096);
    chk("p4096_spacing", div_cyc[1] - div_cyc[0], 4096);
    chk("p4096_quot",    n_quot_raw, 2);
    chk("p4096_qlat",    lat_bad, 0);

    // Switch to 5000: boundary edge still closes a 4096 period
    gen_edges(0, 5000, 2);
    chk("sw_count",      n_div, 4);
    chk("sw_boundary",   dv_vals[2], 4096);
    chk("sw_first_new",  dv_vals[3], 5000);
    chk("sw_divisor",    ifa.divisor, 5000);
    chk("sw_no_short",   n_short, 3);

    // en drop shortly after an accepted period
    rise_wait(0, lat);
    chk("en_latency",    lat, 3);
    chk("en_div_value",  ifa.divisor, 5000);
    repeat (5) @(negedge clk);
    ifa.en = 1'b0;
    ifa.sig_in = 1'b0;
    @(negedge clk);
    chk("en_locked",     ifa.locked, 0);
    chk("en_divisor",    ifa.divisor, 5000);
    gen_edges(0, 100, 3);
    chk("en_no_div",     n_div, 5);
    chk("en_quot_drain", n_quot_raw, 5);
    chk("en_qlat",       lat_bad, 0);

    // Async reset in the middle of a measurement
    ifa.en = 1'b1;
    repeat (2) @(negedge clk);
    gen_edges(0, 3000, 1);
    rise_wait(0, lat);
    chk("ar_latency",    lat, 3);
    chk("ar_divisor_pre", ifa.divisor, 3000);
    chk("ar_locked_pre", ifa.locked, 1);
    repeat (5) @(negedge clk);
    ifa.sig_in = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("ar_divisor",    ifa.divisor, 2048);
    chk("ar_locked",     ifa.locked, 0);
    chk("ar_div_vld",    ifa.div_vld, 0);
    chk("ar_quot_vld",   ifa.quot_vld, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("ar_quot_lost",  n_quot_raw, 5);
    chk("ar_div_count",  n_div, 6);
    chk("ar_ovf_none",   n_ovf, 0);

    // M=14 instance: timeout after one edge
    ifb.en = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    ifb.sig_in = 1'b1;
    c0 = cyc;
    repeat (4) @(negedge clk);
    ifb.sig_in = 1'b0;
    dt = -1;
    for (int i = 0; i < 17000; i++) begin
      @(negedge clk);
      if (ifb.ovf) begin
        dt = cyc - c0;
        break;
      end
    end
    chk("to_delay",      dt, 16386);
    chk("to_div_vld",    ifb.div_vld, 1);
    chk("to_divisor",    ifb.divisor, 16383);
    chk("to_locked",     ifb.locked, 0);
    @(negedge clk);
    chk("to_ovf_pulse",  ifb.ovf, 0);
    chk("to_dv_pulse",   ifb.div_vld, 0);

    gen_edges(1, 3000, 2);
    chk("rc_divisor",    ifb.divisor, 3000);
    chk("rc_locked",     ifb.locked, 1);

    // Edge exactly at counter saturation is a normal period, not a timeout
    ifb.en = 1'b0;
    repeat (2) @(negedge clk);
    ifb.en = 1'b1;
    repeat (2) @(negedge clk);
    gen_edges(1, 16383, 1);
    rise_wait(1, lat);
    chk("max_latency",   lat, 3);
    chk("max_ovf",       ifb.ovf, 0);
    chk("max_divisor",   ifb.divisor, 16383);
    chk("max_locked",    ifb.locked, 1);
    ifb.sig_in = 1'b0;
    repeat (2) @(negedge clk);

    chk("pulse_width",   wide, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
